multicore_work_hub: RTL



---
 rtl/multicore_work_hub.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicore_work_hub.sv
// Work broadcast/restart filter, per-core nonce ranges and golden-nonce collection FIFO.
// Optional statistics counters are enabled with `define MULTICORE_WORK_HUB_STATS_EN.
module multicore_work_hub #(
    parameter int NUM_CORES       = 4,
    parameter int CORE_IDX_W      = 2,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [255:0]            midstate_in,
    input  logic [95:0]             data_in,
    output logic [255:0]            core_midstate,
    output logic [95:0]             core_data,
    output logic [32*NUM_CORES-1:0] core_nonce_base,
    output logic                    core_restart,
    input  logic [NUM_CORES-1:0]    core_gn_valid,
    input  logic [32*NUM_CORES-1:0] core_gn,
    output logic                    gn_valid,
    output logic [31:0]             gn_data,
    output logic [CORE_IDX_W-1:0]   gn_core,
    input  logic                    gn_ready,
    output logic                    fifo_overflow,
`ifdef MULTICORE_WORK_HUB_STATS_EN
    output logic [31:0]             gn_count,
    output logic [15:0]             drop_count,
`endif
    output logic [1:0]              o_dbg_state
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [63:0] NONCE_STEP = 64'h1_0000_0000 / 64'(NUM_CORES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PEND    = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [255:0]                r_cand_mid;
    logic [95:0]                 r_cand_data;
    logic [255:0]                r_core_mid;
    logic [95:0]                 r_core_data;
    logic                        w_capture;
    logic                        w_load;
    logic                        w_flush;
    logic                        w_in_eq_held;
    logic                        w_in_eq_cand;

    logic [NUM_CORES-1:0]        r_pend;
    logic [31:0]                 r_pend_val [NUM_CORES];
    logic [CORE_IDX_W-1:0]       r_rr_ptr;
    logic                        r_overflow;
    logic                        w_grant_any;
    logic [CORE_IDX_W-1:0]       w_grant_idx;
    logic [CORE_IDX_W-1:0]       w_scan_idx;
    logic [NUM_CORES-1:0]        w_grant_vec;
    logic [NUM_CORES-1:0]        w_drop;

    logic [31:0]                 r_fifo_data [DEPTH];
    logic [CORE_IDX_W-1:0]       r_fifo_core [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]    r_count;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_base
        localparam logic [63:0] BASE = NONCE_STEP * 64'(gi);
        assign core_nonce_base[gi*32 +: 32] = BASE[31:0];
    end

    // Work is only accepted after two identical consecutive samples of the host inputs.
    assign w_in_eq_held = ({midstate_in, data_in} == {r_core_mid, r_core_data});
    assign w_in_eq_cand = ({midstate_in, data_in} == {r_cand_mid, r_cand_data});
    assign w_flush      = (r_state == ST_RESTART);

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!w_in_eq_held) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_in_eq_cand) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RESTART;
                end else begin
                    w_capture = 1'b1;
                end
            end
            ST_RESTART: w_next_state = ST_RUN;
            default:    w_next_state = ST_RUN;
        endcase
    end

    // The broadcast registers load on entry to RESTART so cores see new work with the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cand_mid  <= '0;
            r_cand_data <= '0;
            r_core_mid  <= '0;
            r_core_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_cand_mid  <= midstate_in;
                r_cand_data <= data_in;
            end
            if (w_load) begin
                r_core_mid  <= r_cand_mid;
                r_core_data <= r_cand_data;
            end
        end
    end

    assign core_midstate = r_core_mid;
    assign core_data     = r_core_data;
    assign core_restart  = w_flush;
    assign o_dbg_state   = r_state;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_idx  = '0;
        // Descending scan so the pending core closest to r_rr_ptr wins.
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            w_scan_idx = CORE_IDX_W'((int'(r_rr_ptr) + j) % NUM_CORES);
            if (r_pend[w_scan_idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_full = (r_count == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
    assign w_pop  = gn_valid && gn_ready;
    assign w_push = w_grant_any && (!w_full || w_pop) && !w_flush;

    always_comb begin
        w_grant_vec = '0;
        w_drop      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_grant_vec[i] = w_push && (w_grant_idx == CORE_IDX_W'(i));
            w_drop[i]      = !w_flush && core_gn_valid[i] && r_pend[i] && !w_grant_vec[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= '0;
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) r_pend_val[i] <= '0;
        end else if (w_flush) begin
            r_pend <= '0;
        end else begin
            if (w_push)
                r_rr_ptr <= (int'(w_grant_idx) == NUM_CORES - 1) ? '0 : w_grant_idx + 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_gn_valid[i]) begin
                    if (!w_drop[i]) begin
                        r_pend[i]     <= 1'b1;
                        r_pend_val[i] <= core_gn[i*32 +: 32];
                    end
                end else if (w_grant_vec[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
            if (|w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_pend_val[w_grant_idx];
            r_fifo_core[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign gn_valid      = (r_count != '0);
    assign gn_data       = gn_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign gn_core       = gn_valid ? r_fifo_core[r_rd_ptr] : '0;
    assign fifo_overflow = r_overflow;

`ifdef MULTICORE_WORK_HUB_STATS_EN
    logic [31:0] r_gn_count;
    logic [15:0] r_drop_count;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_count} + 17'($countones(w_drop));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gn_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) r_gn_count <= r_gn_count + 1'b1;
            if (|w_drop) r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign gn_count   = r_gn_count;
    assign drop_count = r_drop_count;
`endif

endmodule
